apb_cmd_master: RTL and testbench

APB requester that drains a command FIFO and drives APB transfers. Pops one command word per transfer from the show-ahead read port of a `fifo` instance, executes it as an APB3 read or write, and pushes one response word per transfer into a second `fifo`. Sits between the command/response buffers and the APB bus; it is the consumer end of the command FIFO and the producer end of the response FIFO.

---
 rtl/apb_cmd_pkg.sv | 45 ++++
 rtl/apb_cmd_master_timeout_ctr.sv | 31 +++
 rtl/apb_cmd_master.sv | 106 ++++++++++
 tb/tb_apb_cmd_master.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/apb_cmd_pkg.sv
// Shared types and field layout for the APB command master.
// Command word is {write, addr, wdata}; response word is {timeout_flag, pslverr, prdata}.
package apb_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Fixed low-order field offsets; upper offsets scale with the bus widths.
    localparam int unsigned cmd_wdata_lsb  = 0;
    localparam int unsigned rsp_prdata_lsb = 0;

    function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw);
        return 1 + aw + dw;
    endfunction

    function automatic int unsigned cmd_addr_lsb(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned cmd_write_bit(input int unsigned aw, input int unsigned dw);
        return aw + dw;
    endfunction

    function automatic int unsigned rsp_width(input int unsigned dw);
        return dw + 2;
    endfunction

    function automatic int unsigned rsp_slverr_bit(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned rsp_timeout_bit(input int unsigned dw);
        return dw + 1;
    endfunction

    // Never narrower than one bit, so a disabled timeout still yields a legal counter.
    function automatic int unsigned ctr_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/apb_cmd_master_timeout_ctr.sv
// Saturating ACCESS-cycle counter; expired flags the last permitted wait cycle.
module apb_timeout_ctr
    import apb_cmd_pkg::*;
#(
    parameter int unsigned timeout = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned cw = ctr_width(timeout);

    logic [cw-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != '1)) begin
            cnt <= cnt + cw'(1);
        end
    end

    // A zero timeout never expires.
    assign expired = (timeout != 0) && (cnt == cw'(timeout - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 requester: pops commands from a show-ahead FIFO, runs one APB transfer
// per command and pushes one response word per transfer, in order.
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int unsigned addr_width = 8,
    parameter int unsigned data_width = 32,
    parameter int unsigned timeout    = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      cmd_empty,
    input  logic [cmd_width(addr_width, data_width)-1:0] cmd_dout,
    output logic                                      cmd_rd_en,
    input  logic                                      rsp_full,
    output logic [rsp_width(data_width)-1:0]          rsp_din,
    output logic                                      rsp_wr_en,
    output logic                                      psel,
    output logic                                      penable,
    output logic                                      pwrite,
    output logic [addr_width-1:0]                     paddr,
    output logic [data_width-1:0]                     pwdata,
    input  logic                                      pready,
    input  logic                                      pslverr,
    input  logic [data_width-1:0]                     prdata,
    output logic                                      busy
);

    localparam int unsigned wr_bit   = cmd_write_bit(addr_width, data_width);
    localparam int unsigned addr_lsb = cmd_addr_lsb(data_width);

    state_e state;
    logic   ctr_clear;
    logic   ctr_en;
    logic   expired;

    apb_timeout_ctr #(
        .timeout (timeout)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .expired (expired)
    );

    assign ctr_clear = (state == SETUP);
    assign ctr_en    = (state == ACCESS) && !pready;

    // Reset parks the FSM in IDLE, so the pop strobe is also gated by rst_n.
    assign cmd_rd_en = rst_n && (state == IDLE) && !cmd_empty;
    assign rsp_wr_en = (state == RESP) && !rsp_full;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            rsp_din <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cmd_empty) begin
                        pwrite <= cmd_dout[wr_bit];
                        paddr  <= cmd_dout[addr_lsb +: addr_width];
                        pwdata <= cmd_dout[cmd_wdata_lsb +: data_width];
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_din <= {1'b0, pslverr, pwrite ? {data_width{1'b0}} : prdata};
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= RESP;
                    end else if (expired) begin
                        rsp_din <= {1'b1, 1'b1, {data_width{1'b0}}};
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (!rsp_full) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: zero/wait-state transfers, slave error,
// timeout, disabled timeout, response backpressure and mid-transfer reset.
module tb_apb_cmd_master;
    import apb_cmd_pkg::*;

    localparam int unsigned aw = 8;
    localparam int unsigned dw = 32;
    localparam int unsigned cw = cmd_width(aw, dw);
    localparam int unsigned rw = rsp_width(dw);

    logic          clk = 1'b0;
    logic          rst_n;

    logic          cmd_empty;
    logic [cw-1:0] cmd_dout;
    logic          cmd_rd_en;
    logic          rsp_full;
    logic [rw-1:0] rsp_din;
    logic          rsp_wr_en;
    logic          psel, penable, pwrite;
    logic [aw-1:0] paddr;
    logic [dw-1:0] pwdata;
    logic          pready, pslverr;
    logic [dw-1:0] prdata;
    logic          busy;

    logic          n_cmd_empty;
    logic [cw-1:0] n_cmd_dout;
    logic          n_cmd_rd_en;
    logic          n_rsp_full;
    logic [rw-1:0] n_rsp_din;
    logic          n_rsp_wr_en;
    logic          n_psel, n_penable, n_pwrite;
    logic [aw-1:0] n_paddr;
    logic [dw-1:0] n_pwdata;
    logic          n_pready, n_pslverr;
    logic [dw-1:0] n_prdata;
    logic          n_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pop_cyc = 0;
    int p1;

    apb_cmd_master #(.addr_width(aw), .data_width(dw), .timeout(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_empty(cmd_empty), .cmd_dout(cmd_dout), .cmd_rd_en(cmd_rd_en),
        .rsp_full(rsp_full), .rsp_din(rsp_din), .rsp_wr_en(rsp_wr_en),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr), .prdata(prdata), .busy(busy)
    );

    apb_cmd_master #(.addr_width(aw), .data_width(dw), .timeout(0)) dut_nto (
        .clk(clk), .rst_n(rst_n),
        .cmd_empty(n_cmd_empty), .cmd_dout(n_cmd_dout), .cmd_rd_en(n_cmd_rd_en),
        .rsp_full(n_rsp_full), .rsp_din(n_rsp_din), .rsp_wr_en(n_rsp_wr_en),
        .psel(n_psel), .penable(n_penable), .pwrite(n_pwrite), .paddr(n_paddr), .pwdata(n_pwdata),
        .pready(n_pready), .pslverr(n_pslverr), .prdata(n_prdata), .busy(n_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transfer from pop to push; waits < 0 means pready never rises.
    task automatic xfer(input string tag, input logic w, input logic [aw-1:0] a,
                        input logic [dw-1:0] d, input int waits, input logic [dw-1:0] rd,
                        input logic err, input int stall, input logic [rw-1:0] exp_rsp);
        int acc;
        acc = (waits < 0) ? 16 : waits + 1;
        @(negedge clk);
        cmd_dout = {w, a, d}; cmd_empty = 1'b0; pready = 1'b0; rsp_full = 1'b0; #1;
        check_eq({tag, " pop"}, 64'({cmd_rd_en, busy}), 64'(2'b10));
        pop_cyc = cyc;
        @(negedge clk);
        cmd_empty = 1'b1; pready = 1'b1; pslverr = 1'b1; #1;
        check_eq({tag, " setup"}, 64'({psel, penable, pwrite, cmd_rd_en}), 64'({2'b10, w, 1'b0}));
        check_eq({tag, " paddr"}, 64'(paddr), 64'(a));
        check_eq({tag, " pwdata"}, 64'(pwdata), 64'(d));
        for (int i = 0; i < acc; i++) begin
            @(negedge clk);
            pready = (i == waits); prdata = rd; pslverr = err; #1;
            check_eq({tag, " access"}, 64'({psel, penable, pwrite, paddr, pwdata, rsp_wr_en}),
                     64'({2'b11, w, a, d, 1'b0}));
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            pready = 1'b1; rsp_full = 1'b1; cmd_empty = 1'b0; cmd_dout = '1; #1;
            check_eq({tag, " stall"}, 64'({psel, penable, busy, cmd_rd_en, rsp_wr_en}), 64'(5'b00100));
        end
        @(negedge clk);
        pready = 1'b0; rsp_full = 1'b0; cmd_empty = 1'b1; #1;
        check_eq({tag, " push"}, 64'({psel, penable, rsp_wr_en, cmd_rd_en}), 64'(4'b0010));
        check_eq({tag, " rsp"}, 64'(rsp_din), 64'(exp_rsp));
    endtask

    initial begin
        rst_n = 1'b0; cmd_empty = 1'b0; cmd_dout = {1'b1, 8'hAA, 32'h1};
        rsp_full = 1'b0; pready = 1'b1; pslverr = 1'b0; prdata = '0;
        n_cmd_empty = 1'b1; n_cmd_dout = '0; n_rsp_full = 1'b0;
        n_pready = 1'b0; n_pslverr = 1'b0; n_prdata = '0;
        #1;
        check_eq("reset ctl", 64'({psel, penable, pwrite, busy, cmd_rd_en, rsp_wr_en}), 64'(0));
        check_eq("reset paddr/pwdata", 64'({paddr, pwdata}), 64'(0));
        check_eq("reset rsp_din", 64'(rsp_din), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1; cmd_empty = 1'b1;

        xfer("wr0", 1'b1, 8'h10, 32'hDEADBEEF, 0, 32'hFFFF_FFFF, 1'b0, 0, 34'h0);
        p1 = pop_cyc;
        xfer("rd0", 1'b0, 8'h20, 32'h0, 0, 32'h1234_5678, 1'b0, 0, {2'b00, 32'h1234_5678});
        check_eq("b2b spacing", 64'(pop_cyc - p1), 64'(4));
        xfer("rd3w", 1'b0, 8'h24, 32'h1234, 3, 32'hCAFE_0001, 1'b0, 0, {2'b00, 32'hCAFE_0001});
        xfer("slverr", 1'b0, 8'h40, 32'h0, 0, 32'h55, 1'b1, 0, {2'b01, 32'h55});
        xfer("tmo", 1'b1, 8'h50, 32'hA5A5_A5A5, -1, 32'h0, 1'b0, 0, {2'b11, 32'h0});
        xfer("bp", 1'b0, 8'h60, 32'h0, 1, 32'h600D, 1'b0, 5, {2'b00, 32'h600D});

        // Reset asserted asynchronously in the middle of ACCESS.
        @(negedge clk);
        cmd_dout = {1'b0, 8'h30, 32'h0}; cmd_empty = 1'b0; pready = 1'b0; #1;
        check_eq("arst pop", 64'(cmd_rd_en), 64'(1));
        @(negedge clk);
        cmd_empty = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("arst in access", 64'({psel, penable}), 64'(2'b11));
        #2 rst_n = 1'b0; cmd_empty = 1'b0; #1;
        check_eq("arst drop", 64'({psel, penable, busy, cmd_rd_en, rsp_wr_en}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1; cmd_empty = 1'b1; #1;
        check_eq("arst release", 64'({psel, busy, rsp_wr_en}), 64'(0));
        repeat (3) begin
            @(negedge clk); #1;
            check_eq("arst no rsp", 64'({psel, busy, rsp_wr_en}), 64'(0));
        end
        xfer("post_rst", 1'b1, 8'h70, 32'h0BAD_F00D, 2, 32'hFFFF, 1'b1, 0, {2'b01, 32'h0});

        // A zero timeout leaves the transfer in ACCESS indefinitely.
        @(negedge clk);
        n_cmd_dout = {1'b0, 8'h80, 32'h0}; n_cmd_empty = 1'b0; #1;
        check_eq("nto pop", 64'(n_cmd_rd_en), 64'(1));
        @(negedge clk);
        n_cmd_empty = 1'b1;
        repeat (40) begin
            @(negedge clk); #1;
            check_eq("nto stuck", 64'({n_psel, n_penable, n_busy, n_rsp_wr_en}), 64'(4'b1110));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
